// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage with data memory, byte-lane stores, extending loads and a wait-state stall FSM.
// Optional feature macro: MISALIGN_TRAP_EN (flag misaligned half/word accesses instead of ignoring low address bits).
module mem_access_stage #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] read_data2_mem,
    input  logic [4:0]  rd_mem,
    input  logic [2:0]  funct3_mem,
    input  logic        MemRead_mem,
    input  logic        MemWrite_mem,
    input  logic        MemtoReg_mem,
    input  logic        RegWrite_mem,
    output logic        mem_stall,
    output logic [31:0] read_data_wb,
    output logic [31:0] alu_result_wb,
    output logic [4:0]  rd_wb,
    output logic        MemtoReg_wb,
    output logic        RegWrite_wb,
    output logic        misaligned_wb
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       word, load_data, wdata;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [3:0]        be;
    logic              access, is_load, misaligned, done, we;

    assign access  = MemRead_mem | MemWrite_mem;
    assign is_load = MemRead_mem & ~MemWrite_mem;
    assign waddr   = alu_result_mem[ADDR_W+1:2];
    assign word    = mem[waddr];

`ifdef MISALIGN_TRAP_EN
    logic half_acc, word_acc;
    assign half_acc   = (funct3_mem == 3'b001) || (is_load && funct3_mem == 3'b101);
    assign word_acc   = funct3_mem == 3'b010;
    assign misaligned = access && ((half_acc && alu_result_mem[0]) ||
                                   (word_acc && alu_result_mem[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign byte_sel  = word[8*alu_result_mem[1:0] +: 8];
    assign half_sel  = alu_result_mem[1] ? word[31:16] : word[15:0];
    assign load_data = funct3_mem == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
                       funct3_mem == 3'b001 ? {{16{half_sel[15]}}, half_sel} :
                       funct3_mem == 3'b010 ? word :
                       funct3_mem == 3'b100 ? {24'h0, byte_sel} :
                       funct3_mem == 3'b101 ? {16'h0, half_sel} : 32'h0;

    assign be    = funct3_mem == 3'b000 ? 4'b0001 << alu_result_mem[1:0] :
                   funct3_mem == 3'b001 ? (alu_result_mem[1] ? 4'b1100 : 4'b0011) :
                   funct3_mem == 3'b010 ? 4'b1111 : 4'b0000;
    assign wdata = funct3_mem == 3'b000 ? {4{read_data2_mem[7:0]}} :
                   funct3_mem == 3'b001 ? {2{read_data2_mem[15:0]}} : read_data2_mem;

    assign done = ~mem_stall;
    assign we   = done & MemWrite_mem & ~misaligned;

    // Byte-lane store on the completion edge; a reset held across that edge discards it
    always_ff @(posedge clock)
        if (we && !reset)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];

    // FSM state and wait counter
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end

    // Next state: an aligned access parks in WAIT until the counter drains
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (access && !misaligned && WAIT_CYCLES > 0) begin
                state_nx = WAIT;
                cnt_nx   = 4'(WAIT_CYCLES - 1);
            end
        end else if (cnt != '0)
            cnt_nx = cnt - 4'd1;
        else
            state_nx = IDLE;
    end

    // Stall upstream for the first WAIT_CYCLES cycles of each aligned access
    always_comb
        mem_stall = state == IDLE ? (access && !misaligned && WAIT_CYCLES > 0) : (cnt != '0);

    // MEM/WB boundary: bubble while stalled, completed instruction otherwise
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            read_data_wb  <= '0;
            alu_result_wb <= '0;
            rd_wb         <= '0;
            MemtoReg_wb   <= 1'b0;
            RegWrite_wb   <= 1'b0;
            misaligned_wb <= 1'b0;
        end else begin
            alu_result_wb <= alu_result_mem;
            rd_wb         <= done ? rd_mem : 5'd0;
            MemtoReg_wb   <= done && MemtoReg_mem;
            RegWrite_wb   <= done && RegWrite_mem && !misaligned;
            read_data_wb  <= (done && is_load && !misaligned) ? load_data : 32'h0;
            misaligned_wb <= done && misaligned;
        end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table, hand-written and random checks of mem_access_stage against a byte-array memory model.
module tb_mem_access_stage;
    localparam int W = 2;

    logic        clock, reset;
    logic [31:0] alu_result_mem, read_data2_mem;
    logic [4:0]  rd_mem;
    logic [2:0]  funct3_mem;
    logic        MemRead_mem, MemWrite_mem, MemtoReg_mem, RegWrite_mem;
    logic        mem_stall;
    logic [31:0] read_data_wb, alu_result_wb;
    logic [4:0]  rd_wb;
    logic        MemtoReg_wb, RegWrite_wb, misaligned_wb;

    int errors = 0;
    int checks = 0;
    logic [7:0] bmem [4096];

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr, mw, m2r, rw;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    mem_access_stage #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_CYCLES(W)) dut (
        .clock(clock), .reset(reset),
        .alu_result_mem(alu_result_mem), .read_data2_mem(read_data2_mem),
        .rd_mem(rd_mem), .funct3_mem(funct3_mem),
        .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
        .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
        .mem_stall(mem_stall), .read_data_wb(read_data_wb), .alu_result_wb(alu_result_wb),
        .rd_wb(rd_wb), .MemtoReg_wb(MemtoReg_wb), .RegWrite_wb(RegWrite_wb),
        .misaligned_wb(misaligned_wb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_result_mem = 0; read_data2_mem = 0; rd_mem = 0; funct3_mem = 0;
        MemRead_mem = 0; MemWrite_mem = 0; MemtoReg_mem = 0; RegWrite_mem = 0;
    endtask

    // Apply one instruction, check every stall/bubble cycle and the completed MEM/WB values
    task automatic run(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic [2:0] f3, input logic mr, input logic mw,
                       input logic m2r, input logic rw);
        logic        ld, acc, mis;
        int          n, bi, hi, wi;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w, er;
        ld  = mr & ~mw;
        acc = mr | mw;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = acc && ((((f3 == 3'd1) || (ld && f3 == 3'd5)) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00));
`endif
        n  = (acc && !mis) ? W + 1 : 1;
        bi = int'(a[11:0]);
        hi = int'({a[11:1], 1'b0});
        wi = int'({a[11:2], 2'b00});
        b  = bmem[bi];
        h  = {bmem[hi+1], bmem[hi]};
        w  = {bmem[wi+3], bmem[wi+2], bmem[wi+1], bmem[wi]};
        er = 32'h0;
        if (ld && !mis)
            case (f3)
                3'd0: er = {{24{b[7]}}, b};
                3'd1: er = {{16{h[15]}}, h};
                3'd2: er = w;
                3'd4: er = {24'h0, b};
                3'd5: er = {16'h0, h};
                default: er = 32'h0;
            endcase
        alu_result_mem = a; read_data2_mem = d; rd_mem = rd; funct3_mem = f3;
        MemRead_mem = mr; MemWrite_mem = mw; MemtoReg_mem = m2r; RegWrite_mem = rw;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check("stall", {63'h0, mem_stall}, {63'h0, k < n - 1});
            @(posedge clock);
            #1;
            if (k < n - 1)
                check("bubble", {24'h0, RegWrite_wb, MemtoReg_wb, rd_wb, misaligned_wb, read_data_wb}, 64'h0);
        end
        check("read_data_wb", {32'h0, read_data_wb}, {32'h0, er});
        check("alu_result_wb", {32'h0, alu_result_wb}, {32'h0, a});
        check("rd_wb", {59'h0, rd_wb}, {59'h0, rd});
        check("ctl_wb", {61'h0, RegWrite_wb, MemtoReg_wb, misaligned_wb}, {61'h0, rw & ~mis, m2r, mis});
        if (mw && !mis)
            case (f3)
                3'd0: bmem[bi] = d[7:0];
                3'd1: begin bmem[hi] = d[7:0]; bmem[hi+1] = d[15:8]; end
                3'd2: for (int i = 0; i < 4; i++) bmem[wi+i] = d[8*i +: 8];
                default: ;
            endcase
    endtask

    initial begin
        tbl[0]  = '{32'h10,   32'hDEADBEEF, 5'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{32'h10,   32'h0,        5'd5, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[2]  = '{32'h20,   32'h11223344, 5'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{32'h21,   32'h00000080, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{32'h21,   32'h0,        5'd6, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFF80};
        tbl[5]  = '{32'h21,   32'h0,        5'd6, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000080};
        tbl[6]  = '{32'h20,   32'h0,        5'd6, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11228044};
        tbl[7]  = '{32'h32,   32'hABCD8001, 5'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{32'h32,   32'h0,        5'd8, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF8001};
        tbl[9]  = '{32'h32,   32'h0,        5'd8, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00008001};
        tbl[10] = '{32'h1234, 32'h0,        5'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[11] = '{32'h50,   32'hCAFEF00D, 5'd3, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0};
        tbl[12] = '{32'h50,   32'h0,        5'd3, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D};
        tbl[13] = '{32'h10,   32'h0,        5'd4, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[14] = '{32'h10,   32'h0,        5'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[15] = '{32'h10,   32'h0,        5'd4, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[16] = '{32'h1010, 32'h0,        5'd4, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};

        idle_inputs();
        reset = 1'b1;
        #1;
        check("reset_outputs", {16'h0, RegWrite_wb, MemtoReg_wb, rd_wb, misaligned_wb, read_data_wb},
              64'h0);
        check("reset_alu_wb", {32'h0, alu_result_wb}, 64'h0);
        check("reset_stall", {63'h0, mem_stall}, 64'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 32; i++)
            run(32'(4 * i), 32'hA5A5A5A5 ^ (32'h01010101 * 32'(i)), 5'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            run(tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].f3, tbl[i].mr, tbl[i].mw, tbl[i].m2r, tbl[i].rw);
            check($sformatf("tbl%0d_data", i), {32'h0, read_data_wb}, {32'h0, tbl[i].exp});
        end

        run(32'h40, 32'h11111111, 5'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        alu_result_mem = 32'h40; read_data2_mem = 32'h55; funct3_mem = 3'd2; MemWrite_mem = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midwait_reset_out", {RegWrite_wb, MemtoReg_wb, rd_wb, misaligned_wb, read_data_wb, alu_result_wb[23:0]},
              64'h0);
        check("midwait_reset_idle_stall", {63'h0, mem_stall}, 64'h1);
        idle_inputs();
        reset = 1'b0;
        #1;
        check("after_reset_stall", {63'h0, mem_stall}, 64'h0);
        @(posedge clock);
        #1;
        run(32'h40, 32'h0, 5'd2, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        check("aborted_store", {32'h0, read_data_wb}, {32'h0, 32'h11111111});

        run(32'h42, 32'h0, 5'd9, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef MISALIGN_TRAP_EN
        check("lw_0x42", {31'h0, misaligned_wb, read_data_wb}, {31'h0, 1'b1, 32'h0});
`else
        check("lw_0x42", {31'h0, misaligned_wb, read_data_wb}, {31'h0, 1'b0, 32'h11111111});
`endif
        run(32'h41, 32'h0000BEEF, 5'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(32'h40, 32'h0, 5'd9, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            logic [1:0]  rw_sel;
            a = $urandom & 32'hFFFF_F07F;
            rw_sel = 2'($urandom_range(0, 3));
            run(a, $urandom, 5'($urandom), 3'($urandom), rw_sel[0], rw_sel[1],
                1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
